// File: rtl/cpu_pkg.sv
// cpu_pkg: register-file geometry and dump-reader state encoding shared across the CPU debug slice
package cpu_pkg;
   localparam int REG_WIDTH = 32;
   localparam int REG_ADDR_LEN = 5;
   typedef enum logic [1:0] {IDLE, READ, SEND, DONE} dump_state_t;
endpackage

// File: rtl/regfile_dump_reader_if.sv
// regfile_dump_reader_if: valid/ready word stream carrying one register value, its index and a last flag
interface regfile_dump_reader_if
   import cpu_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH,
   parameter int ADDRESS_LENGTH = REG_ADDR_LEN
);
   logic [WIDTH-1:0] data;
   logic [ADDRESS_LENGTH-1:0] addr;
   logic last;
   logic valid;
   logic ready;
   modport master (output data, addr, last, valid, input ready);
   modport slave (input data, addr, last, valid, output ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks every register-file address on start and streams the values out with a last flag
module regfile_dump_reader
   import cpu_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH,
   parameter int ADDRESS_LENGTH = REG_ADDR_LEN,
   parameter int SIZE = 1 << ADDRESS_LENGTH
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic abort,
   output logic [ADDRESS_LENGTH-1:0] rf_addr,
   input  logic [WIDTH-1:0] rf_data,
   regfile_dump_reader_if.master dump,
   output logic busy,
   output logic done
);
   localparam logic [ADDRESS_LENGTH-1:0] LAST_ADDR = ADDRESS_LENGTH'(SIZE - 1);
   dump_state_t state, next;
   logic [ADDRESS_LENGTH-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= next;
   always_comb begin
      next = state;
      unique case (state)
         IDLE: next = start ? READ : IDLE;
         READ: next = abort ? IDLE : SEND;
         SEND: next = abort ? IDLE : dump.ready ? (dump.last ? DONE : READ) : SEND;
         DONE: next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         dump.data <= '0;
         dump.addr <= '0;
         dump.last <= 1'b0;
      end else if (state == IDLE) begin
         if (start) cnt <= '0;
      end else if (abort) begin
         cnt <= '0;
      end else if (state == READ) begin
         dump.data <= rf_data;
         dump.addr <= cnt;
         dump.last <= cnt == LAST_ADDR;
      end else if (state == SEND && dump.ready && !dump.last) begin
         cnt <= cnt + 1'b1;
      end
   // outside READ the port keeps presenting the last address read, never the reset counter
   assign rf_addr = state == READ ? cnt : dump.addr;
   assign dump.valid = state == SEND;
   assign busy = state != IDLE;
   assign done = state == DONE;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed dump scenarios checked against a queue of expected words
module tb_regfile_dump_reader;
   import cpu_pkg::*;
   typedef struct {
      logic [4:0] addr;
      logic [31:0] data;
      logic last;
   } word_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic [4:0] rf_addr;
   logic [31:0] rf_data;
   logic busy, done;
   logic [31:0] regs [32];
   logic rnd_ready = 1'b0;
   word_t q[$];
   int errors = 0;
   int checks = 0;
   int accepted = 0;
   regfile_dump_reader_if dump ();
   regfile_dump_reader dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .rf_addr(rf_addr), .rf_data(rf_data), .dump(dump),
      .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   assign rf_data = (rf_addr == 5'd0) ? 32'd0 : regs[rf_addr];
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask
   always @(negedge clk)
      if (!rst && dump.valid) begin
         if (q.size() == 0) check("extra_word", 64'(dump.addr), 64'hFFFF);
         else begin
            check("word", 64'({dump.last, dump.addr, dump.data}), 64'({q[0].last, q[0].addr, q[0].data}));
            if (dump.ready && !abort) begin
               void'(q.pop_front());
               accepted++;
            end
         end
      end
   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_ready) dump.ready = 1'($urandom_range(0, 1));
   endtask
   task automatic push_dump(input int ovr, input logic [31:0] val);
      word_t w;
      for (int i = 0; i < 32; i++) begin
         w.addr = 5'(i);
         w.data = (i == ovr) ? val : 32'(i) * 32'h11111111;
         w.last = i == 31;
         q.push_back(w);
      end
   endtask
   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask
   task automatic wait_addr(input logic [4:0] a, input int budget);
      int n = 0;
      while (!(dump.valid && dump.addr == a) && n < budget) begin
         step();
         n++;
      end
      check("reach_addr", 64'(dump.valid && dump.addr == a), 64'd1);
   endtask
   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         step();
         n++;
      end
      check("done_seen", 64'(done), 64'd1);
   endtask
   task automatic finish_dump(input string tag);
      check({tag, "_words"}, 64'(accepted), 64'd32);
      check({tag, "_queue"}, 64'(q.size()), 64'd0);
   endtask
   initial begin
      int n;
      logic all_busy;
      logic seen_done;
      for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h11111111;
      dump.ready = 1'b1;
      #12;
      check("rst_outputs", 64'({dump.valid, dump.last, busy, done, dump.addr, rf_addr}), 64'd0);
      check("rst_data", 64'(dump.data), 64'd0);
      step();
      rst = 1'b0;
      step();
      check("idle_busy", 64'(busy), 64'd0);
      push_dump(-1, 32'd0);
      pulse_start();
      n = 1;
      all_busy = busy;
      while (!done && n < 200) begin
         step();
         n++;
         all_busy &= busy;
      end
      check("done_latency", 64'(n), 64'd65);
      check("busy_throughout", 64'(all_busy), 64'd1);
      finish_dump("full");
      step();
      check("done_one_cycle", 64'({done, busy}), 64'd0);
      accepted = 0;
      rnd_ready = 1'b1;
      push_dump(-1, 32'd0);
      pulse_start();
      wait_done(2000);
      rnd_ready = 1'b0;
      dump.ready = 1'b1;
      finish_dump("stall");
      step();
      accepted = 0;
      push_dump(-1, 32'd0);
      pulse_start();
      wait_addr(5'd10, 200);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_outputs", 64'({dump.valid, busy, done}), 64'd0);
      check("abort_words", 64'(accepted), 64'd10);
      check("abort_pending", 64'(q.size()), 64'd22);
      q.delete();
      seen_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         seen_done |= done | dump.valid;
      end
      check("abort_quiet", 64'(seen_done), 64'd0);
      accepted = 0;
      push_dump(-1, 32'd0);
      pulse_start();
      wait_done(200);
      finish_dump("restart");
      step();
      accepted = 0;
      push_dump(-1, 32'd0);
      pulse_start();
      wait_addr(5'd3, 200);
      pulse_start();
      wait_done(200);
      finish_dump("restart_ignored");
      step();
      check("no_queued_start", 64'(busy), 64'd0);
      accepted = 0;
      push_dump(-1, 32'd0);
      pulse_start();
      wait_addr(5'd7, 200);
      #3 rst = 1'b1;
      #1;
      check("async_rst_ctrl", 64'({dump.valid, dump.last, busy, done, dump.addr, rf_addr}), 64'd0);
      check("async_rst_data", 64'(dump.data), 64'd0);
      q.delete();
      step();
      #2 rst = 1'b0;
      step();
      step();
      step();
      check("post_rst_idle", 64'({busy, dump.valid, done}), 64'd0);
      accepted = 0;
      push_dump(20, 32'hDEADBEEF);
      pulse_start();
      wait_addr(5'd5, 200);
      regs[20] = 32'hDEADBEEF;
      regs[2] = 32'h12345678;
      wait_done(200);
      finish_dump("coherence");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
